// File: rtl/ant_scan_pkg.sv
// Shared constants and state type for the antenna scan sequencer.
package ant_scan_pkg;

    localparam int unsigned N_ANT   = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned POW_W   = 32;
    localparam int unsigned SEL_LAT = 1;

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_e;

endpackage

// File: rtl/pow_max_track.sv
// Running maximum of tagged power samples; strict greater-than, so ties keep the earlier index.
// Outputs reflect the registered maximum merged with the sample presented this cycle.
module pow_max_track
    import ant_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic [IDX_W-1:0] idx,
    input  logic [POW_W-1:0] pow,
    output logic [IDX_W-1:0] best_idx,
    output logic [POW_W-1:0] best_pow,
    output logic             found
);

    logic [IDX_W-1:0] best_idx_q;
    logic [POW_W-1:0] best_pow_q;
    logic             found_q;
    logic             upd;

    // First accepted sample always loads, even a zero power.
    assign upd      = valid && (!found_q || (pow > best_pow_q));
    assign best_idx = upd ? idx : best_idx_q;
    assign best_pow = upd ? pow : best_pow_q;
    assign found    = found_q | valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_idx_q <= '0;
            best_pow_q <= '0;
            found_q    <= 1'b0;
        end else if (clear) begin
            found_q    <= 1'b0;
        end else if (upd) begin
            best_idx_q <= idx;
            best_pow_q <= pow;
            found_q    <= 1'b1;
        end
    end

endmodule

// File: rtl/ant_scan_ctrl.sv
// Steps the registered 16:1 power selector through every antenna and reports the strongest
// enabled one with a single-cycle done pulse.
module ant_scan_ctrl
    import ant_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_ANT-1:0] ant_mask,
    output logic [IDX_W-1:0] ant_posinfo,
    input  logic [POW_W-1:0] ant_pow,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] best_idx,
    output logic [POW_W-1:0] best_pow,
    output logic             no_ant
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] posinfo_q, posinfo_d;
    logic [N_ANT-1:0] mask_q, mask_d;
    logic             v1_q, v1_d, v2_q;
    logic [IDX_W-1:0] i1_q, i1_d, i2_q;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] best_idx_q;
    logic [POW_W-1:0] best_pow_q;
    logic             no_ant_q;
    logic             trk_clear, res_load;
    logic             trk_valid, trk_found;
    logic [IDX_W-1:0] trk_idx;
    logic [POW_W-1:0] trk_pow;

    // Stage 1 tags the index being driven; stage 2 lines up with ant_pow after SEL_LAT.
    assign trk_valid = v2_q && mask_q[i2_q];

    pow_max_track u_track (
        .clk      (clk),
        .rst      (rst),
        .clear    (trk_clear),
        .valid    (trk_valid),
        .idx      (i2_q),
        .pow      (ant_pow),
        .best_idx (trk_idx),
        .best_pow (trk_pow),
        .found    (trk_found)
    );

    always_comb begin
        state_d   = state_q;
        posinfo_d = posinfo_q;
        mask_d    = mask_q;
        v1_d      = 1'b0;
        i1_d      = i1_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        trk_clear = 1'b0;
        res_load  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SCAN;
                    mask_d    = ant_mask;
                    trk_clear = 1'b1;
                    posinfo_d = '0;
                    v1_d      = 1'b1;
                    i1_d      = '0;
                    busy_d    = 1'b1;
                end
            end
            SCAN: begin
                if (posinfo_q == IDX_W'(N_ANT - 1)) begin
                    state_d = FLUSH;
                end else begin
                    posinfo_d = posinfo_q + IDX_W'(1);
                    v1_d      = 1'b1;
                    i1_d      = posinfo_q + IDX_W'(1);
                end
            end
            FLUSH: begin
                // Last sample sits in stage 2 once stage 1 has drained.
                if (!v1_q) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    res_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            posinfo_q  <= '0;
            mask_q     <= '0;
            v1_q       <= 1'b0;
            i1_q       <= '0;
            v2_q       <= 1'b0;
            i2_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            best_idx_q <= '0;
            best_pow_q <= '0;
            no_ant_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            posinfo_q <= posinfo_d;
            mask_q    <= mask_d;
            v1_q      <= v1_d;
            i1_q      <= i1_d;
            v2_q      <= v1_q;
            i2_q      <= i1_q;
            busy_q    <= busy_d;
            done_q    <= done_d;
            if (res_load) begin
                best_idx_q <= trk_found ? trk_idx : '0;
                best_pow_q <= trk_found ? trk_pow : '0;
                no_ant_q   <= ~|mask_q;
            end
        end
    end

    assign ant_posinfo = posinfo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign best_idx    = best_idx_q;
    assign best_pow    = best_pow_q;
    assign no_ant      = no_ant_q;

endmodule

// File: tb/tb_ant_scan_ctrl.sv
// Directed bench for ant_scan_ctrl with a registered selector model driving ant_pow.
module tb_ant_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] ant_mask;
    logic [3:0]  ant_posinfo;
    logic [31:0] ant_pow;
    logic        busy;
    logic        done;
    logic [3:0]  best_idx;
    logic [31:0] best_pow;
    logic        no_ant;

    logic [31:0] pow_tab [16];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  prev_idx = 4'd0;
    logic [31:0] prev_pow = 32'd0;

    always #5 clk = ~clk;

    // Selector model: one register stage between index and power.
    always @(posedge clk) ant_pow <= pow_tab[ant_posinfo];

    ant_scan_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ant_mask    (ant_mask),
        .ant_posinfo (ant_posinfo),
        .ant_pow     (ant_pow),
        .busy        (busy),
        .done        (done),
        .best_idx    (best_idx),
        .best_pow    (best_pow),
        .no_ant      (no_ant)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 16; k++) pow_tab[k] = 32'(100 * k);
    endtask

    task automatic set_fill(input logic [31:0] v);
        for (int k = 0; k < 16; k++) pow_tab[k] = v;
    endtask

    // Launches a scan from IDLE and checks timing plus the final result.
    task automatic run_scan(input string tag, input logic [15:0] m, input logic [3:0] e_idx,
                            input logic [31:0] e_pow, input logic e_none);
        int done_at;
        done_at  = -1;
        ant_mask = m;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, " busy@E0"}, 32'(busy), 32'd1);
        check_eq({tag, " idx@E0"}, 32'(ant_posinfo), 32'd0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 3)  check_eq({tag, " idx@E3"}, 32'(ant_posinfo), 32'd3);
            if (c == 10) check_eq({tag, " hold_pow"}, best_pow, prev_pow);
            if (c == 16) begin
                check_eq({tag, " busy@E16"}, 32'(busy), 32'd1);
                check_eq({tag, " idx@E16"}, 32'(ant_posinfo), 32'd15);
            end
            if (done) begin
                done_at = c;
                break;
            end
        end
        check_eq({tag, " done_at"}, 32'(done_at), 32'd17);
        check_eq({tag, " busy@done"}, 32'(busy), 32'd0);
        check_eq({tag, " best_idx"}, 32'(best_idx), 32'(e_idx));
        check_eq({tag, " best_pow"}, best_pow, e_pow);
        check_eq({tag, " no_ant"}, 32'(no_ant), 32'(e_none));
        @(posedge clk); #1;
        check_eq({tag, " done_pulse"}, 32'(done), 32'd0);
        prev_idx = e_idx;
        prev_pow = e_pow;
    endtask

    initial begin
        int n_done;
        int d1;
        int d2;
        rst      = 1'b1;
        start    = 1'b0;
        ant_mask = 16'h0;
        set_fill(32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        check_eq("rst posinfo", 32'(ant_posinfo), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        set_ramp();
        run_scan("ramp", 16'hFFFF, 4'd15, 32'd1500, 1'b0);

        set_fill(32'd0);
        pow_tab[2] = 32'd5000;
        pow_tab[6] = 32'd300;
        run_scan("mask", 16'h00F0, 4'd6, 32'd300, 1'b0);

        set_fill(32'd1);
        pow_tab[3] = 32'hFFFF_FFFF;
        pow_tab[9] = 32'hFFFF_FFFF;
        run_scan("tie", 16'hFFFF, 4'd3, 32'hFFFF_FFFF, 1'b0);

        run_scan("none", 16'h0000, 4'd0, 32'd0, 1'b1);
        set_fill(32'd0);
        run_scan("top", 16'h8000, 4'd15, 32'd0, 1'b0);

        // Extra starts at E5/E10 ignored; start in the done cycle launches a second scan.
        set_ramp();
        ant_mask = 16'hFFFF;
        start    = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        n_done = 0;
        d1     = -1;
        d2     = -1;
        for (int c = 1; c <= 40; c++) begin
            start = (c == 5 || c == 10 || c == 18);
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                if (n_done == 1) d1 = c;
                else d2 = c;
            end
        end
        start = 1'b0;
        check_eq("busy_start n_done", 32'(n_done), 32'd2);
        check_eq("busy_start first", 32'(d1), 32'd17);
        check_eq("busy_start second", 32'(d2), 32'd35);
        check_eq("busy_start best_idx", 32'(best_idx), 32'd15);
        check_eq("busy_start best_pow", best_pow, 32'd1500);

        // Asynchronous reset mid-scan at index 7.
        ant_mask = 16'hFFFF;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_eq("midrst idx7", 32'(ant_posinfo), 32'd7);
        rst = 1'b1;
        #1;
        check_eq("midrst posinfo", 32'(ant_posinfo), 32'd0);
        check_eq("midrst busy", 32'(busy), 32'd0);
        check_eq("midrst best_idx", 32'(best_idx), 32'd0);
        check_eq("midrst best_pow", best_pow, 32'd0);
        check_eq("midrst no_ant", 32'(no_ant), 32'd0);
        n_done = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check_eq("midrst no_done", 32'(n_done), 32'd0);
        prev_idx = 4'd0;
        prev_pow = 32'd0;
        run_scan("post_rst", 16'hFFFF, 4'd15, 32'd1500, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
